// File: rtl/dac.sv
// -----------------------------------------------------------------------------
// dac -- AXI4-Stream frame buffer feeding a parallel 8-bit DAC socket.
//
// A frame of sample bytes is received on the AXI4-Stream slave, stored in a
// block-RAM frame buffer, then played back one sample per dac_clk period.
// While a frame plays, the stream is back-pressured (axis_tready=0). Frames
// longer than DEPTH bytes are truncated: the excess beats are accepted and
// thrown away, and frame_err pulses once.
//
// Parameters
//   DEPTH  frame buffer size in bytes (power of 2, >= 2)
//   DIV    dac_clk period in axis_aclk cycles (even, >= 2)
//
// Ports
//   axis_aclk     in   sole clock, rising edge
//   axis_aresetn  in   asynchronous active-low reset
//   axis_tvalid   in   stream beat valid
//   axis_tready   out  stream ready (low only while playing)
//   axis_tdata    in   8-bit sample byte
//   axis_tlast    in   last beat of frame
//   dac_clk       out  DAC sample clock (DAC captures on its rising edge)
//   dac_data      out  DAC sample, changes on dac_clk falling edge
//   busy          out  high while a frame is playing
//   frame_err     out  one-cycle pulse after a frame overflows the buffer
// -----------------------------------------------------------------------------
module dac #(
    parameter int DEPTH = 256,
    parameter int DIV   = 4
) (
    input  logic       axis_aclk,
    input  logic       axis_aresetn,
    input  logic       axis_tvalid,
    output logic       axis_tready,
    input  logic [7:0] axis_tdata,
    input  logic       axis_tlast,
    output logic       dac_clk,
    output logic [7:0] dac_data,
    output logic       busy,
    output logic       frame_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;          // room for length == DEPTH
    localparam int PHW = $clog2(DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DROP,
        S_PLAY
    } state_t;

    state_t         r_state;
    logic [PW-1:0]  r_wr_ptr;             // beats stored; equals frame length in PLAY
    logic [PW-1:0]  r_rd_ptr;             // next sample to play
    logic [PHW-1:0] r_phase;
    logic           r_dac_clk;
    logic           r_frame_err;
    logic           r_played;             // a sample has been played since reset
    logic [7:0]     r_mem [DEPTH];
    logic [7:0]     r_rd_data;

    logic           w_accept;
    logic           w_store;
    logic           w_wrap;
    logic           w_full_next;
    logic           w_load;
    logic [PHW-1:0] w_phase_next;

    assign axis_tready  = (r_state != S_PLAY);
    assign busy         = (r_state == S_PLAY);
    assign w_accept     = axis_tvalid && axis_tready;
    assign w_store      = w_accept && ((r_state == S_IDLE) || (r_state == S_RECV));
    // The wrap edge is where phase returns to 0, i.e. dac_clk falls.
    assign w_wrap       = (r_phase == PHW'(DIV - 1));
    assign w_phase_next = w_wrap ? '0 : r_phase + PHW'(1);
    assign w_full_next  = (r_wr_ptr == PW'(DEPTH - 1));
    // rd_ptr == wr_ptr means the last sample has already had its full period.
    assign w_load       = (r_state == S_PLAY) && w_wrap && (r_rd_ptr != r_wr_ptr);

    // Frame buffer: one write port, one registered read port. The read is
    // issued in the cycle where phase = DIV-1, so the RAM output register
    // itself becomes the DAC sample register at the dac_clk falling edge.
    // Reading only while already in PLAY guarantees the final beat written
    // on the PLAY-entry edge is visible to the first read.
    always_ff @(posedge axis_aclk) begin
        if (w_store) begin
            r_mem[r_wr_ptr[AW-1:0]] <= axis_tdata;
        end
        if (w_load) begin
            r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_phase     <= '0;
            r_dac_clk   <= 1'b0;
            r_frame_err <= 1'b0;
            r_played    <= 1'b0;
        end else begin
            r_phase     <= w_phase_next;
            // dac_clk tracks the phase register: high in the upper half period.
            r_dac_clk   <= (w_phase_next >= PHW'(DIV / 2));
            r_frame_err <= 1'b0;

            case (r_state)
                S_IDLE, S_RECV: begin
                    if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                        if (axis_tlast) begin
                            r_state  <= S_PLAY;
                            r_rd_ptr <= '0;
                        end else if (w_full_next) begin
                            r_state     <= S_DROP;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_state <= S_RECV;
                        end
                    end
                end
                S_DROP: begin
                    // Buffer already holds DEPTH bytes; discard until tlast.
                    if (w_accept && axis_tlast) begin
                        r_state  <= S_PLAY;
                        r_rd_ptr <= '0;
                    end
                end
                S_PLAY: begin
                    if (w_wrap) begin
                        if (r_rd_ptr == r_wr_ptr) begin
                            r_state  <= S_IDLE;
                            r_wr_ptr <= '0;
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PW'(1);
                            r_played <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dac_clk   = r_dac_clk;
    // The RAM read register carries no reset; mid-scale is shown until the
    // first sample after reset has been played.
    assign dac_data  = r_played ? r_rd_data : 8'h80;
    assign frame_err = r_frame_err;

endmodule
